// File: rtl/alu_iter.sv
// Iterative execute unit: single-cycle logic/arith ops, shifts at 1 bit per cycle.
// Latency: 1 edge for non-shift ops, N+1 edges for shift amount N>0; result held until out_ready.
module alu_iter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_control,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               illegal
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]           op_q, op_d;
    logic                 illegal_q, illegal_d;

    // acc doubles as the shift register and the held result.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_d      = alu_control;
                        illegal_d = 1'b0;
                        state_d   = S_DONE;
                        case (alu_control)
                            OP_ADD:  acc_d = a + b;
                            OP_SUB:  acc_d = a - b;
                            OP_AND:  acc_d = a & b;
                            OP_OR:   acc_d = a | b;
                            OP_XOR:  acc_d = a ^ b;
                            OP_SLT:  acc_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                            OP_SLTU: acc_d = {{(WIDTH-1){1'b0}}, (a < b)};
                            OP_SLL, OP_SRL, OP_SRA: begin
                                acc_d = a;
                                cnt_d = b[SHAMT_W-1:0];
                                if (b[SHAMT_W-1:0] != '0) begin
                                    state_d = S_SHIFT;
                                end
                            end
                            default: begin
                                acc_d     = '0;
                                illegal_d = 1'b1;
                            end
                        endcase
                    end
                end
                S_SHIFT: begin
                    case (op_q)
                        OP_SLL:  acc_d = {acc_q[WIDTH-2:0], 1'b0};
                        OP_SRL:  acc_d = {1'b0, acc_q[WIDTH-1:1]};
                        default: acc_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
                    endcase
                    cnt_d = cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = acc_q;
    assign zero      = (acc_q == '0);
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_iter.sv
// Randomized and directed bench for alu_iter against a plain-arithmetic reference model.
module tb_alu_iter;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [3:0]    alu_control = 4'd0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          in_ready, out_valid, zero, illegal;
    logic [W-1:0]  result;

    int n_cmp = 0;
    int n_fail = 0;

    alu_iter #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .alu_control(alu_control),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        n = int'(y[4:0]);
        case (op)
            4'd0: return x + y;
            4'd1: return x - y;
            4'd2: return x & y;
            4'd3: return x | y;
            4'd4: return x ^ y;
            4'd5: return ($signed(x) < $signed(y)) ? 1 : 0;
            4'd6: return (x < y) ? 1 : 0;
            4'd7: return x << n;
            4'd8: return x >> n;
            4'd9: return W'($signed(x) >>> n);
            default: return '0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [W-1:0] y);
        if (op >= 4'd7 && op <= 4'd9 && y[4:0] != 5'd0) return int'(y[4:0]) + 1;
        return 1;
    endfunction

    // Caller sits 1 time unit after a rising edge. Returns edges from accept to out_valid.
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic z, output logic il, output int lat);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        alu_control = op; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; alu_control = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        r = result; z = zero; il = illegal;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, result, zero, illegal} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h z=%b ill=%b, want rdy=1 vld=0 res=0 z=1 ill=0",
                     in_ready, out_valid, result, zero, illegal);
        end
        #9 reset_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [3:0]   ops [6] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd9, 4'd7};
        logic [W-1:0] av  [6] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h1234ABCD};
        logic [W-1:0] bv  [6] = '{32'd1, 32'd5, 32'd1, 32'd1, 32'd31, 32'd0};
        logic [W-1:0] ev  [6] = '{32'h80000000, 32'd0, 32'd1, 32'd0, 32'hFFFFFFFF, 32'h1234ABCD};
        int           lv  [6] = '{1, 1, 1, 1, 32, 1};
        logic [W-1:0] r;
        logic z, il;
        int lat;
        for (int i = 0; i < 6; i++) begin
            do_op(ops[i], av[i], bv[i], r, z, il, lat);
            n_cmp++;
            if (r !== ev[i] || z !== (ev[i] == 0) || il !== 1'b0 || lat != lv[i]) begin
                n_fail++;
                $display("FAIL directed_%0d: got res=%h z=%b ill=%b lat=%0d, want res=%h z=%b ill=0 lat=%0d",
                         i, r, z, il, lat, ev[i], (ev[i] == 0), lv[i]);
            end
            take();
        end
    endtask

    task automatic test_random();
        logic [W-1:0] r, x, y, e;
        logic [3:0] op;
        logic z, il;
        int lat;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            x = $urandom;
            y = (i % 4 == 0) ? x : $urandom;
            if (i % 7 == 0) x = '0;
            e = model(op, x, y);
            do_op(op, x, y, r, z, il, lat);
            n_cmp++;
            if (r !== e || z !== (e == 0) || il !== (op > 4'd9) || lat != model_lat(op, y)) begin
                n_fail++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: got res=%h z=%b ill=%b lat=%0d, want res=%h z=%b ill=%b lat=%0d",
                         i, op, x, y, r, z, il, lat, e, (e == 0), (op > 4'd9), model_lat(op, y));
            end
            take();
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] r;
        logic z, il;
        int lat;
        do_op(4'd0, 32'd10, 32'd20, r, z, il, lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; alu_control = 4'd1; a = 32'd99; b = 32'd1;
            n_cmp++;
            if (result !== 32'd30 || out_valid !== 1'b1 || in_ready !== 1'b0 || zero !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d: got res=%h vld=%b rdy=%b z=%b, want res=1e vld=1 rdy=0 z=0",
                         i, result, out_valid, in_ready, zero);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        take();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd30) begin
            n_fail++;
            $display("FAIL hold_release: got vld=%b rdy=%b res=%h, want vld=0 rdy=1 res=1e", out_valid, in_ready, result);
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] r;
        logic z, il;
        int lat;
        int seen = 0;
        alu_control = 4'd8; a = $urandom; b = 32'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_shift: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        end
        repeat (30) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL flush_no_output: got %0d valid cycles, want 0", seen);
        end
        do_op(4'd0, 32'd1, 32'd2, r, z, il, lat);
        n_cmp++;
        if (r !== 32'd3 || lat != 1) begin
            n_fail++;
            $display("FAIL flush_next_add: got res=%h lat=%0d, want res=3 lat=1", r, lat);
        end
        take();
        flush = 1'b1; in_valid = 1'b1; alu_control = 4'd0;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_accept: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        end
        do_op(4'd0, 32'd4, 32'd4, r, z, il, lat);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_done: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] r;
        logic z, il;
        int lat;
        alu_control = 4'd7; a = 32'hDEADBEEF; b = 32'd16; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, result, zero, illegal} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_shift: got rdy=%b vld=%b res=%h z=%b ill=%b, want rdy=1 vld=0 res=0 z=1 ill=0",
                     in_ready, out_valid, result, zero, illegal);
        end
        @(negedge clk); reset_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_pulse: got vld=%b, want 0", out_valid);
            end
        end
        do_op(4'd12, $urandom, $urandom, r, z, il, lat);
        n_cmp++;
        if (r !== 32'd0 || z !== 1'b1 || il !== 1'b1 || lat != 1) begin
            n_fail++;
            $display("FAIL illegal_op: got res=%h z=%b ill=%b lat=%0d, want res=0 z=1 ill=1 lat=1", r, z, il, lat);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || illegal !== 1'b0 || result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_done: got vld=%b ill=%b res=%h, want vld=0 ill=0 res=0", out_valid, illegal, result);
        end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
